// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch FSM. Issues one memory request at a time,
//            holds the returned word until decode accepts it, and handles
//            taken-branch redirects, including dropping a response that was
//            already in flight. A misaligned branch target locks the unit
//            in a sticky fault state until reset.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  // instruction memory
  output logic        mem_req_o,
  output logic [63:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  // decode side
  output logic [31:0] instr_o,
  output logic [63:0] instr_pc_o,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  // branch redirect
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  input  logic [63:0] redirect_imm_i,
  // status
  output logic        fetch_fault_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q;
  logic [63:0] pc_q;
  logic        discard_q;
  logic        mem_req_q;
  logic [63:0] mem_addr_q;
  logic [31:0] instr_q;
  logic [63:0] instr_pc_q;
  logic        instr_valid_q;
  logic        fetch_fault_q;

  // Branch target: the immediate is in half-word units, carry out of bit 63 dropped.
  logic [63:0] target;
  assign target = redirect_pc_i + (redirect_imm_i << 1);

  // Fetch FSM; redirect outranks every other transition, FAULT ignores all inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      discard_q     <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= 64'h0;
      instr_q       <= 32'h0;
      instr_pc_q    <= 64'h0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else if (state_q != FAULT) begin
      if (redirect_i) begin
        instr_valid_q <= 1'b0;
        pc_q          <= target;
        if (target[1]) begin
          state_q       <= FAULT;
          fetch_fault_q <= 1'b1;
          mem_req_q     <= 1'b0;
          discard_q     <= 1'b0;
        end else if (state_q == FETCH && !mem_ready_i) begin
          // Request must complete at its old address; drop that response later.
          discard_q <= 1'b1;
        end else begin
          // IDLE, HOLD, or response arriving this edge (dropped): go to target now.
          state_q    <= FETCH;
          mem_req_q  <= 1'b1;
          mem_addr_q <= target;
          discard_q  <= 1'b0;
        end
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= FETCH;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
          end
          FETCH: begin
            if (mem_ready_i) begin
              if (discard_q) begin
                // Stale response; pc already holds the redirect target.
                discard_q  <= 1'b0;
                mem_addr_q <= pc_q;
              end else begin
                instr_q       <= mem_rdata_i;
                instr_pc_q    <= mem_addr_q;
                instr_valid_q <= 1'b1;
                pc_q          <= mem_addr_q + 64'd4;
                mem_req_q     <= 1'b0;
                state_q       <= HOLD;
              end
            end
          end
          HOLD: begin
            if (instr_valid_q && instr_ready_i) begin
              instr_valid_q <= 1'b0;
              state_q       <= FETCH;
              mem_req_q     <= 1'b1;
              mem_addr_q    <= pc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_req_o     = mem_req_q;
  assign mem_addr_o    = mem_addr_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instr_pc_q;
  assign instr_valid_o = instr_valid_q;
  assign fetch_fault_o = fetch_fault_q;

endmodule
`default_nettype wire
